// File: rtl/dsec_host.sv
// dsec_host: host-side initiator for the data-stream compression/encryption
// device. Loads the three 3DES keys, streams payload words into the device
// under rdy backpressure, collects encrypted output through a one-entry
// holding register, and latches the device error code until cleared.
// Optional: define DSEC_HOST_TIMEOUT_EN to add a stalled-beat timeout that
// forces ERR with an all-ones error code.
module dsec_host #(
    parameter int DATA_W     = 64,
    parameter int DRAIN_IDLE = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] key1,
    input  logic [DATA_W-1:0] key2,
    input  logic [DATA_W-1:0] key3,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    input  logic              src_last,
    output logic              src_ready,
    input  logic              dev_rdy,
    input  logic              dev_error,
    input  logic              dev_out_valid,
    input  logic [DATA_W-1:0] dev_data_out,
    output logic [DATA_W-1:0] dev_data_in,
    output logic              dev_key_config,
    output logic              dev_in_valid,
    output logic              dev_out_rcvd,
    output logic [DATA_W-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] err_code
);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_DATA, S_DRAIN, S_ERR} state_t;

    localparam int IW = $clog2(DRAIN_IDLE + 1);

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] key_q [3];
    logic [DATA_W-1:0] key_d [3];
    logic [1:0]        key_idx_q,   key_idx_d;
    logic [IW-1:0]     idle_cnt_q,  idle_cnt_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              done_q,      done_d;
    logic [DATA_W-1:0] err_code_q,  err_code_d;
    // Set on entry to ERR by dev_error: the device shows its code one cycle later.
    logic              err_cap_q,   err_cap_d;

`ifdef DSEC_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     to_cnt_q,    to_cnt_d;
`else
    logic              timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
`endif

    assign snk_valid = hold_full_q;
    assign snk_data  = hold_data_q;
    assign done      = done_q;
    assign err_code  = err_code_q;
    assign err       = (state_q == S_ERR);
    assign busy      = (state_q == S_KEY) || (state_q == S_DATA) || (state_q == S_DRAIN);

    // Device-side handshakes; forced low while rst is asserted.
    always_comb begin
        dev_key_config = 1'b0;
        dev_data_in    = '0;
        dev_in_valid   = 1'b0;
        src_ready      = 1'b0;
        dev_out_rcvd   = 1'b0;
        case (state_q)
            S_KEY: begin
                dev_key_config = 1'b1;
                dev_data_in    = key_q[key_idx_q];
                dev_in_valid   = dev_rdy;
            end
            S_DATA: begin
                dev_data_in    = src_data;
                dev_in_valid   = src_valid & dev_rdy;
                src_ready      = src_valid & dev_rdy;
            end
            default: ;
        endcase
        if (state_q != S_ERR)
            dev_out_rcvd = dev_out_valid & (~hold_full_q | snk_ready);
        if (rst) begin
            dev_in_valid = 1'b0;
            src_ready    = 1'b0;
            dev_out_rcvd = 1'b0;
        end
    end

    // Next-state logic for the session FSM, holding register and error capture.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_idx_d   = key_idx_q;
        idle_cnt_d  = idle_cnt_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        done_d      = 1'b0;
        err_code_d  = err_code_q;
        err_cap_d   = err_cap_q;

        // Load wins over drain: a same-cycle capture keeps snk_valid high.
        if (dev_out_rcvd) begin
            hold_full_d = 1'b1;
            hold_data_d = dev_data_out;
        end else if (snk_ready) begin
            hold_full_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d[0]  = key1;
                    key_d[1]  = key2;
                    key_d[2]  = key3;
                    key_idx_d = 2'd0;
                    state_d   = S_KEY;
                end
            end
            S_KEY: begin
                if (dev_in_valid)
                    key_idx_d = key_idx_q + 2'd1;
                if (dev_error) begin
                    state_d   = S_ERR;
                    err_cap_d = 1'b1;
                end else if (dev_in_valid && key_idx_q == 2'd2) begin
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (dev_error) begin
                    state_d   = S_ERR;
                    err_cap_d = 1'b1;
                end else if (dev_in_valid && src_last) begin
                    state_d    = S_DRAIN;
                    idle_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (dev_error) begin
                    state_d   = S_ERR;
                    err_cap_d = 1'b1;
                end else if (dev_out_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IW'(DRAIN_IDLE - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                err_cap_d = 1'b0;
                if (err_cap_q)
                    err_code_d = dev_data_out;
                if (clear)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DSEC_HOST_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        if (state_q == S_KEY || state_q == S_DATA) begin
            if (dev_in_valid) begin
                to_cnt_d = '0;
            end else if ((state_q == S_KEY || src_valid) && !dev_rdy) begin
                if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    to_cnt_d = '0;
                    if (!dev_error) begin
                        state_d    = S_ERR;
                        err_code_d = '1;
                        err_cap_d  = 1'b0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        end else begin
            to_cnt_d = '0;
        end
`endif
    end

    // State registers; synchronous reset clears everything, data included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_q[0]    <= '0;
            key_q[1]    <= '0;
            key_q[2]    <= '0;
            key_idx_q   <= '0;
            idle_cnt_q  <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            done_q      <= 1'b0;
            err_code_q  <= '0;
            err_cap_q   <= 1'b0;
`ifdef DSEC_HOST_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_idx_q   <= key_idx_d;
            idle_cnt_q  <= idle_cnt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            done_q      <= done_d;
            err_code_q  <= err_code_d;
            err_cap_q   <= err_cap_d;
`ifdef DSEC_HOST_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dsec_host.sv
// Self-checking bench for dsec_host: a behavioural session model compared
// on every falling edge, plus directed scenarios with literal expectations.
module tb_dsec_host;

    localparam int DW = 64;
    localparam int DI = 64;
    localparam int PH_IDLE = 0, PH_KEY = 1, PH_DATA = 2, PH_DRAIN = 3, PH_ERR = 4;

    logic          clk = 1'b0;
    logic          rst, start, clear;
    logic [DW-1:0] key1, key2, key3;
    logic [DW-1:0] src_data;
    logic          src_valid, src_last, src_ready;
    logic          dev_rdy, dev_error, dev_out_valid;
    logic [DW-1:0] dev_data_out, dev_data_in;
    logic          dev_key_config, dev_in_valid, dev_out_rcvd;
    logic [DW-1:0] snk_data;
    logic          snk_valid, snk_ready;
    logic          busy, done, err;
    logic [DW-1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;
    bit dut_xfer;
    logic [DW-1:0] pay_exp[$];

    // model state
    int            m_ph;
    bit            m_known = 1'b0;
    logic [DW-1:0] m_key[3];
    int            m_kn, m_pidx, m_idle;
    bit            m_done, m_cap;
    logic [DW-1:0] m_ec;
    logic [DW-1:0] m_sq[$];

    dsec_host #(.DATA_W(DW), .DRAIN_IDLE(DI), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .key1(key1), .key2(key2), .key3(key3),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
        .dev_rdy(dev_rdy), .dev_error(dev_error), .dev_out_valid(dev_out_valid),
        .dev_data_out(dev_data_out), .dev_data_in(dev_data_in),
        .dev_key_config(dev_key_config), .dev_in_valid(dev_in_valid), .dev_out_rcvd(dev_out_rcvd),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        start = 0; clear = 0; src_valid = 0; src_last = 0; src_data = '0;
        dev_rdy = 0; dev_error = 0; dev_out_valid = 0; dev_data_out = '0; snk_ready = 1;
    endtask

    task automatic do_reset;
        quiet();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Reference model: expected outputs from the session rules, then advance.
    always @(negedge clk) begin : model
        bit e_iv, e_sr, e_or, e_busy;
        e_iv = 0; e_sr = 0; e_or = 0;
        dut_xfer = src_ready;
        if (rst) begin
            chk("rst_in_valid", 64'(dev_in_valid), 64'd0);
            chk("rst_src_ready", 64'(src_ready), 64'd0);
            chk("rst_out_rcvd", 64'(dev_out_rcvd), 64'd0);
            m_ph = PH_IDLE; m_kn = 0; m_pidx = 0; m_idle = 0;
            m_done = 0; m_cap = 0; m_ec = '0; m_sq.delete();
            m_known = 1;
        end else if (m_known) begin
            if (m_ph == PH_KEY)  e_iv = dev_rdy;
            if (m_ph == PH_DATA) e_iv = src_valid & dev_rdy;
            e_sr = (m_ph == PH_DATA) && e_iv;
            e_or = (m_ph != PH_ERR) && dev_out_valid && (m_sq.size() == 0 || snk_ready);
            e_busy = (m_ph == PH_KEY) || (m_ph == PH_DATA) || (m_ph == PH_DRAIN);
            chk("busy", 64'(busy), 64'(e_busy));
            chk("err", 64'(err), 64'(m_ph == PH_ERR));
            chk("done", 64'(done), 64'(m_done));
            chk("key_config", 64'(dev_key_config), 64'(m_ph == PH_KEY));
            chk("in_valid", 64'(dev_in_valid), 64'(e_iv));
            chk("src_ready", 64'(src_ready), 64'(e_sr));
            chk("out_rcvd", 64'(dev_out_rcvd), 64'(e_or));
            chk("snk_valid", 64'(snk_valid), 64'(m_sq.size() != 0));
            chk("err_code", err_code, m_ec);
            if (m_sq.size() != 0) chk("snk_data", snk_data, m_sq[0]);
            if (e_iv && m_ph == PH_KEY) chk("key_beat", dev_data_in, m_key[m_kn]);
            if (e_iv && m_ph == PH_DATA) begin
                if (m_pidx < pay_exp.size()) chk("payload_beat", dev_data_in, pay_exp[m_pidx]);
                else chk("payload_extra", 64'(m_pidx), 64'(pay_exp.size() - 1));
            end
            // advance
            if (snk_ready && m_sq.size() != 0) void'(m_sq.pop_front());
            if (e_or) m_sq.push_back(dev_data_out);
            m_done = 0;
            case (m_ph)
                PH_IDLE: if (start) begin
                    m_key[0] = key1; m_key[1] = key2; m_key[2] = key3;
                    m_kn = 0; m_pidx = 0; m_ph = PH_KEY;
                end
                PH_KEY: begin
                    if (dev_error) begin m_ph = PH_ERR; m_cap = 1; end
                    else if (e_iv) begin
                        if (m_kn == 2) m_ph = PH_DATA; else m_kn++;
                    end
                end
                PH_DATA: begin
                    if (e_iv) m_pidx++;
                    if (dev_error) begin m_ph = PH_ERR; m_cap = 1; end
                    else if (e_iv && src_last) begin m_ph = PH_DRAIN; m_idle = 0; end
                end
                PH_DRAIN: begin
                    if (dev_error) begin m_ph = PH_ERR; m_cap = 1; end
                    else begin
                        m_idle = dev_out_valid ? 0 : m_idle + 1;
                        if (m_idle == DI) begin m_done = 1; m_ph = PH_IDLE; end
                    end
                end
                default: begin
                    if (m_cap) m_ec = dev_data_out;
                    m_cap = 0;
                    if (clear) m_ph = PH_IDLE;
                end
            endcase
        end
    end

    // Start a session and check the three key beats literally (dev_rdy held high).
    task automatic start_keys(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3);
        key1 = k1; key2 = k2; key3 = k3;
        start = 1;
        tick();
        start = 0;
        dev_rdy = 1;
        #1; chk("kb1_cfg", 64'(dev_key_config), 64'd1); chk("kb1_v", 64'(dev_in_valid), 64'd1); chk("kb1_d", dev_data_in, k1);
        tick();
        #1; chk("kb2_cfg", 64'(dev_key_config), 64'd1); chk("kb2_d", dev_data_in, k2);
        tick();
        #1; chk("kb3_cfg", 64'(dev_key_config), 64'd1); chk("kb3_d", dev_data_in, k3);
        tick();
        #1; chk("kdone_cfg", 64'(dev_key_config), 64'd0); chk("kdone_busy", 64'(busy), 64'd1);
    endtask

    task automatic rand_session(input int n, input bit inj);
        int src_i, post, cyc, err_at;
        bit fin;
        logic [63:0] code;
        pay_exp.delete();
        for (int i = 0; i < n; i++) pay_exp.push_back({$urandom, $urandom});
        key1 = {$urandom, $urandom}; key2 = {$urandom, $urandom}; key3 = {$urandom, $urandom};
        dev_error = 1;             // ignored in IDLE
        tick();
        dev_error = 0;
        start = 1;
        tick();
        start = 0;
        src_i = 0; post = 0; cyc = 0; fin = 0;
        err_at = inj ? int'($urandom_range(2, 3 + 2 * n)) : -10;
        while (!fin && cyc < 4000) begin
            dev_rdy       = ($urandom_range(0, 99) < 60);
            snk_ready     = ($urandom_range(0, 99) < 60);
            src_valid     = (src_i < n) && ($urandom_range(0, 99) < 70);
            src_data      = (src_i < n) ? pay_exp[src_i] : {$urandom, $urandom};
            src_last      = (src_i == n - 1);
            if (src_i >= n) post++;
            dev_out_valid = (post < 40) && ($urandom_range(0, 99) < 40);
            dev_data_out  = {$urandom, $urandom};
            dev_error     = (cyc == err_at);
            tick();
            cyc++;
            if (dut_xfer) src_i++;
            if (done || err) fin = 1;
        end
        if (!fin) begin
            n_checks++; n_errors++;
            $display("FAIL session_timeout: got no done/err after %0d cycles, required completion", cyc);
        end
        if (inj) begin
            chk("inj_err", 64'(err), 64'd1);
            code = {$urandom, $urandom};
            quiet();
            dev_data_out = code;
            tick();
            chk("inj_err_code", err_code, code);
            clear = 1;
            tick();
            clear = 0;
            chk("inj_cleared", 64'(err), 64'd0);
        end else begin
            chk("sess_src_all", 64'(src_i), 64'(n));
        end
        quiet();
        tick();
    endtask

    initial begin : global_guard
        #3_000_000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "global timeout");
    end

    initial begin : main
        logic [63:0] w[4];
        logic [63:0] got[$];
        bit pat[7];
        int si, k;
        bit xf;
        quiet();
        key1 = '0; key2 = '0; key3 = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        // Reset state
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err_code", err_code, 64'd0);
        chk("reset_snk_valid", 64'(snk_valid), 64'd0);
        chk("reset_snk_data", snk_data, 64'd0);
        chk("reset_dev_data_in", dev_data_in, 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        // Key load, backpressure, output handshake, drain/done
        w[0] = 64'h1111_0000_0000_0001; w[1] = 64'h2222_0000_0000_0002;
        w[2] = 64'h3333_0000_0000_0003; w[3] = 64'h4444_0000_0000_0004;
        pay_exp.delete();
        for (int i = 0; i < 4; i++) pay_exp.push_back(w[i]);
        snk_ready = 0;
        start_keys(64'h0123456789ABCDEF, 64'h1122334455667788, 64'h99AABBCCDDEEFF00);
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        si = 0;
        for (int p = 0; p < 7; p++) begin
            src_valid = (si < 4);
            src_data  = w[si % 4];
            src_last  = (si == 3);
            dev_rdy   = pat[p];
            #1;
            chk("bp_src_ready", 64'(src_ready), 64'((si < 4) && pat[p]));
            xf = src_ready;
            if (dev_in_valid) got.push_back(dev_data_in);
            tick();
            if (xf) si++;
        end
        src_valid = 0; src_last = 0; dev_rdy = 0;
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_word", got[i], w[i]);

        dev_out_valid = 1; dev_data_out = 64'hA1; snk_ready = 0;
        #1; chk("hs_rcvd_a1", 64'(dev_out_rcvd), 64'd1);
        tick();
        dev_data_out = 64'hA2;
        #1; chk("hs_hold_a2", 64'(dev_out_rcvd), 64'd0); chk("hs_snk_a1", snk_data, 64'hA1); chk("hs_snk_v", 64'(snk_valid), 64'd1);
        tick();
        snk_ready = 1;
        #1; chk("hs_rcvd_a2", 64'(dev_out_rcvd), 64'd1); chk("hs_snk_a1b", snk_data, 64'hA1);
        tick();
        chk("hs_snk_a2", snk_data, 64'hA2); chk("hs_snk_v2", 64'(snk_valid), 64'd1);
        dev_out_valid = 0;
        k = 0;
        while (!done && k < 200) begin
            tick();
            k++;
            if (k == 1) chk("hs_snk_empty", 64'(snk_valid), 64'd0);
            if (k < DI) chk("drain_not_done", 64'(done), 64'd0);
        end
        chk("drain_idle_cycles", 64'(k), 64'd64);
        chk("drain_busy", 64'(busy), 64'd0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);

        // Error in DATA
        pay_exp.delete();
        start_keys(64'hAAAA, 64'hBBBB, 64'hCCCC);
        dev_error = 1;
        tick();
        dev_error = 0; dev_data_out = 64'hDEAD; dev_out_valid = 1; src_valid = 1; dev_rdy = 1; snk_ready = 0;
        #1;
        chk("err_flag", 64'(err), 64'd1);
        chk("err_in_valid", 64'(dev_in_valid), 64'd0);
        chk("err_out_rcvd", 64'(dev_out_rcvd), 64'd0);
        chk("err_src_ready", 64'(src_ready), 64'd0);
        tick();
        chk("err_code_dead", err_code, 64'hDEAD);
        dev_out_valid = 0; src_valid = 0; dev_data_out = 64'h0;
        clear = 1;
        tick();
        clear = 0;
        chk("clear_err", 64'(err), 64'd0);
        chk("clear_busy", 64'(busy), 64'd0);
        chk("clear_code_held", err_code, 64'hDEAD);

        // Reset mid-DATA
        pay_exp.delete();
        pay_exp.push_back(64'h5151);
        quiet();
        start_keys(64'h1, 64'h2, 64'h3);
        src_valid = 1; src_data = 64'h5151; dev_rdy = 0; dev_out_valid = 1; dev_data_out = 64'h55; snk_ready = 0;
        tick();
        rst = 1;
        #1;
        chk("mid_rst_in_valid", 64'(dev_in_valid), 64'd0);
        chk("mid_rst_src_ready", 64'(src_ready), 64'd0);
        chk("mid_rst_out_rcvd", 64'(dev_out_rcvd), 64'd0);
        tick();
        rst = 0;
        quiet();
        #1;
        chk("mrst_snk_valid", 64'(snk_valid), 64'd0);
        chk("mrst_snk_data", snk_data, 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_err_code", err_code, 64'd0);
        chk("mrst_dev_data_in", dev_data_in, 64'd0);
        chk("mrst_key_config", 64'(dev_key_config), 64'd0);
        start_keys(64'hFEED_0001, 64'hFEED_0002, 64'hFEED_0003);
        do_reset();

        // Randomized sessions
        for (int s = 0; s < 12; s++)
            rand_session(int'($urandom_range(1, 10)), (s % 3 == 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dsec_host.md
Name: dsec_host

Overview:
- Host-side initiator for the data-stream compression/encryption device.
- Loads the three 3DES keys, then streams payload words from an upstream source into the device, honouring its rdy backpressure.
- Collects encrypted output words with the out_valid/out_rcvd handshake and presents them to a downstream sink.
- Detects device errors, latches the error code and halts until cleared.

Parameters:
- DATA_W, 64: word width; must match the device data path.
- DRAIN_IDLE, 64: consecutive cycles without out_valid in DRAIN before the stream is declared finished.
- TIMEOUT, 1024: cycles of rdy low while a beat is pending before a timeout (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse in IDLE: latch key1..key3 and begin a session
- clear  in  1  leave ERR, return to IDLE
- key1, key2, key3  in  DATA_W each  3DES keys, sampled on start
- src_data  in  DATA_W  payload word
- src_valid  in  1  payload word valid
- src_last  in  1  marks the final payload word
- src_ready  out  1  payload word accepted this cycle
- dev_rdy  in  1  device rdy
- dev_error  in  1  device error
- dev_out_valid  in  1  device out_valid
- dev_data_out  in  DATA_W  device data_out
- dev_data_in  out  DATA_W  to device data_in
- dev_key_config  out  1  to device key_config
- dev_in_valid  out  1  to device in_valid
- dev_out_rcvd  out  1  to device out_rcvd
- snk_data  out  DATA_W  output word
- snk_valid  out  1  output word valid
- snk_ready  in  1  sink accepts
- busy  out  1  high in KEY, DATA, DRAIN
- done  out  1  one-cycle pulse at session end
- err  out  1  high in ERR
- err_code  out  DATA_W  latched device error code

Behaviour:
- Reset: all registered state clears on rst=1 at a clk edge, including mid-session.
  - FSM goes to IDLE.
  - All outputs go to 0: dev_data_in, key regs, err_code, snk_data, done, snk_valid.
  - Since dev_in_valid, dev_out_rcvd and src_ready are combinational, they are also 0 during reset.
- States: IDLE, KEY, DATA, DRAIN, ERR.
- IDLE:
  - Accepts no payload; src_ready=0.
  - start=1 latches the keys, sets key_idx=0 and moves to KEY.
- KEY:
  - dev_key_config=1; dev_data_in=key[key_idx]; dev_in_valid=dev_rdy.
  - A beat transfers on each cycle with dev_in_valid=1 and key_idx increments.
  - After the third transfer (key_idx=2): next state is DATA, dev_key_config returns to 0.
  - Exactly three key beats per session.
- DATA:
  - dev_key_config=0; dev_data_in=src_data.
  - dev_in_valid = src_valid & dev_rdy; src_ready = dev_in_valid.
  - Transfer with src_last=1: next state is DRAIN.
  - dev_rdy=0 holds the word; no beat is lost or duplicated.
- DRAIN:
  - No input beats.
  - idle_cnt counts cycles with dev_out_valid=0 and resets to 0 on any dev_out_valid.
  - idle_cnt reaching DRAIN_IDLE-1: done=1 for one cycle, next state is IDLE.
- Output path (all states except ERR):
  - One-entry holding register; hold_full drives snk_valid, the register drives snk_data.
  - dev_out_rcvd = dev_out_valid & (~hold_full | snk_ready).
  - When dev_out_rcvd=1, dev_data_out is captured that cycle.
  - Capture and sink drain in the same cycle is allowed; snk_valid stays 1 and the new word is loaded.
  - A word handed to the sink is never overwritten before snk_ready.
- Error:
  - dev_error=1 in KEY, DATA or DRAIN: next state is ERR.
  - On the first cycle in ERR, err_code <= dev_data_out; the device presents its code one cycle after raising error.
  - In ERR: dev_in_valid=0, dev_out_rcvd=0, src_ready=0, err=1. A pending snk word remains until snk_ready.
  - clear=1 in ERR: next state is IDLE, err=0; err_code holds until the next error or rst.
  - dev_error in IDLE is ignored.
- Simultaneous events:
  - rst overrides everything.
  - dev_error overrides a same-cycle src_last or key completion; the beat still transfers, then the FSM enters ERR.
  - start outside IDLE is ignored.

Optional Feature:
- Macro: DSEC_HOST_TIMEOUT_EN.
- Defined:
  - to_cnt counts cycles in KEY/DATA with a pending beat (KEY, or DATA with src_valid=1) and dev_rdy=0; it resets on any transfer.
  - Reaching TIMEOUT-1: next state is ERR with err_code = 64'hFFFF_FFFF_FFFF_FFFF; dev_data_out is not sampled.
- Undefined: no counter; the FSM waits on dev_rdy indefinitely.

Test Plan:
- Key load: start with key1=64'h0123456789ABCDEF, key2=..., key3=...; dev_rdy=1 -> exactly 3 beats with key_config=1 carrying key1,key2,key3 in order, then DATA.
- Backpressure: 4 payload words with dev_rdy toggled 1,0,0,1... -> device receives the 4 words in order, src_ready only on transfer cycles, no duplicates.
- Output handshake: dev_out_valid=1 for words 64'hA1, 64'hA2 with snk_ready=0 then 1 -> A1 held and out_rcvd withheld for A2 until sink drains; sink sees A1, then A2.
- Drain/done: last word sent, no dev_out_valid for 64 cycles -> done pulse exactly on the 64th idle cycle, FSM in IDLE, busy=0.
- Error: dev_error in DATA, dev_data_out=64'hDEAD next cycle -> err=1, err_code=64'hDEAD, in_valid/out_rcvd stay 0; clear -> IDLE, err=0.
- Reset mid-DATA: rst=1 while dev_rdy=0 with a pending word -> all outputs 0 on the next edge; a fresh start reloads all 3 keys.
